// File: rtl/sync_fifo_pkg.sv
// Shared helpers and types for the single-clock FIFO controller.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package sync_fifo_pkg;

  // Pointer width: one extra wrap bit above the memory address.
  function automatic int ptr_w(input int addrsize);
    return addrsize + 1;
  endfunction

  // Number of entries addressed by an address of the given width.
  function automatic int depth_of(input int addrsize);
    return 1 << addrsize;
  endfunction

  // Address width needed to cover a given depth.
  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Registered status flags, all derived from the next occupancy.
  typedef struct packed {
    logic full;
    logic afull;
    logic empty;
    logic aempty;
  } flags_t;

endpackage

// File: rtl/sync_fifo_ctrl_fifomem.sv
// Dual-port storage array: synchronous write, combinational read.
// Latency: a write is visible on rdata the cycle after its edge; read is 0-cycle.
// Backpressure: none; the caller gates writes, and wfull blocks them as a guard.
module fifomem #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4
) (
  input  logic                wclk,
  input  logic                wclken,
  input  logic                wfull,
  input  logic [ADDRSIZE-1:0] waddr,
  input  logic [ADDRSIZE-1:0] raddr,
  input  logic [DATASIZE-1:0] wdata,
  output logic [DATASIZE-1:0] rdata
);

  localparam int DEPTH = 1 << ADDRSIZE;

  logic [DATASIZE-1:0] mem [DEPTH];

  assign rdata = mem[raddr];

  // Store the incoming word; contents are deliberately not reset.
  always_ff @(posedge wclk) begin
    if (wclken && !wfull) mem[waddr] <= wdata;
  end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FWFT FIFO: pointers, occupancy and registered flags around fifomem.
// Latency: a written word reaches rdata one cycle after its write edge.
// Backpressure: writes dropped while wfull, reads dropped while rempty; SYNC_FIFO_ERR_EN adds sticky overflow/underflow.
module sync_fifo_ctrl
  import sync_fifo_pkg::*;
#(
  parameter int DATASIZE     = 8,
  parameter int ADDRSIZE     = 4,
  parameter int AFULL_LEVEL  = (1 << ADDRSIZE) - 2,
  parameter int AEMPTY_LEVEL = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                winc,
  input  logic [DATASIZE-1:0] wdata,
  output logic                wfull,
  output logic                walmost_full,
  input  logic                rinc,
  output logic [DATASIZE-1:0] rdata,
  output logic                rempty,
  output logic                ralmost_empty,
  output logic [ADDRSIZE:0]   count
`ifdef SYNC_FIFO_ERR_EN
  ,
  input  logic                err_clr,
  output logic                overflow,
  output logic                underflow
`endif
);

  localparam int DEPTH = depth_of(ADDRSIZE);

  typedef logic [ptr_w(ADDRSIZE)-1:0] ptr_t;

  localparam ptr_t DEPTH_C  = ptr_t'(DEPTH);
  localparam ptr_t AFULL_C  = ptr_t'(AFULL_LEVEL);
  localparam ptr_t AEMPTY_C = ptr_t'(AEMPTY_LEVEL);

  if (!(AEMPTY_LEVEL > 0 && AEMPTY_LEVEL < AFULL_LEVEL && AFULL_LEVEL < DEPTH)) begin : g_bad_levels
    $fatal(1, "sync_fifo_ctrl: thresholds must satisfy 0 < AEMPTY_LEVEL < AFULL_LEVEL < DEPTH");
  end

  ptr_t   wptr, rptr, cnt_nxt;
  flags_t flg, flg_nxt;
  logic   we, re;

  assign we = winc & ~flg.full;
  assign re = rinc & ~flg.empty;

  assign wfull         = flg.full;
  assign walmost_full  = flg.afull;
  assign rempty        = flg.empty;
  assign ralmost_empty = flg.aempty;

  // Next occupancy and the flags it implies; flags are registered from this.
  always_comb begin
    cnt_nxt        = count + ptr_t'(we) - ptr_t'(re);
    flg_nxt        = '0;
    flg_nxt.full   = (cnt_nxt == DEPTH_C);
    flg_nxt.afull  = (cnt_nxt >= AFULL_C);
    flg_nxt.empty  = (cnt_nxt == '0);
    flg_nxt.aempty = (cnt_nxt <= AEMPTY_C);
  end

  // Pointer, occupancy and flag state; reset forces empty so stale words never look valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      flg   <= '{full: 1'b0, afull: 1'b0, empty: 1'b1, aempty: 1'b1};
    end else begin
      if (we) wptr <= wptr + 1'b1;
      if (re) rptr <= rptr + 1'b1;
      count <= cnt_nxt;
      flg   <= flg_nxt;
    end
  end

`ifdef SYNC_FIFO_ERR_EN
  // Sticky illegal-request flags; a new event in the same cycle beats err_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (winc && flg.full)       overflow <= 1'b1;
      else if (err_clr)           overflow <= 1'b0;
      if (rinc && flg.empty)      underflow <= 1'b1;
      else if (err_clr)           underflow <= 1'b0;
    end
  end
`endif

  fifomem #(
    .DATASIZE(DATASIZE),
    .ADDRSIZE(ADDRSIZE)
  ) u_mem (
    .wclk  (clk),
    .wclken(we),
    .wfull (wfull),
    .waddr (wptr[ADDRSIZE-1:0]),
    .raddr (rptr[ADDRSIZE-1:0]),
    .wdata (wdata),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl (DATASIZE=8, ADDRSIZE=4, default thresholds).
// Inputs change on the falling edge; outputs are sampled just before the next rising edge.
// Expected data lives in a queue filled on accepted writes and drained on accepted reads.
module tb_sync_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       winc = 1'b0;
  logic       rinc = 1'b0;
  logic [7:0] wdata = '0;
  logic       wfull, walmost_full, rempty, ralmost_empty;
  logic [7:0] rdata;
  logic [4:0] count;
`ifdef SYNC_FIFO_ERR_EN
  logic       err_clr = 1'b0;
  logic       overflow, underflow;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  sync_fifo_ctrl #(
    .DATASIZE(8),
    .ADDRSIZE(4),
    .AFULL_LEVEL(14),
    .AEMPTY_LEVEL(2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .winc         (winc),
    .wdata        (wdata),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .rinc         (rinc),
    .rdata        (rdata),
    .rempty       (rempty),
    .ralmost_empty(ralmost_empty),
    .count        (count)
`ifdef SYNC_FIFO_ERR_EN
    ,
    .err_clr      (err_clr),
    .overflow     (overflow),
    .underflow    (underflow)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare status outputs against the occupancy of the reference queue.
  task automatic check_state();
    int sz;
    sz = exp_q.size();
    check("count",         32'(count),         32'(sz));
    check("rempty",        32'(rempty),        32'(sz == 0));
    check("wfull",         32'(wfull),         32'(sz == 16));
    check("walmost_full",  32'(walmost_full),  32'(sz >= 14));
    check("ralmost_empty", 32'(ralmost_empty), 32'(sz <= 2));
  endtask

  // One clock of stimulus; called just after a falling edge.
  task automatic cyc(input logic w, input logic r, input logic [7:0] d);
    logic m_we, m_re;
    m_we  = w && (exp_q.size() != 16);
    m_re  = r && (exp_q.size() != 0);
    winc  = w;
    rinc  = r;
    wdata = d;
    if (m_re) check("rdata", 32'(rdata), 32'(exp_q[0]));
    @(posedge clk);
    if (m_re) void'(exp_q.pop_front());
    if (m_we) exp_q.push_back(d);
    @(negedge clk);
    winc = 1'b0;
    rinc = 1'b0;
    check_state();
  endtask

  typedef struct {
    logic       w;
    logic       r;
    logic [7:0] d;
    int         exp_cnt;
    logic       exp_empty;
    logic       exp_full;
    logic       rd_chk;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vt[6];

  initial begin
    vt[0] = '{w: 1'b1, r: 1'b0, d: 8'hA5, exp_cnt: 1, exp_empty: 1'b0, exp_full: 1'b0, rd_chk: 1'b1, exp_rd: 8'hA5};
    vt[1] = '{w: 1'b0, r: 1'b1, d: 8'h00, exp_cnt: 0, exp_empty: 1'b1, exp_full: 1'b0, rd_chk: 1'b0, exp_rd: 8'h00};
    vt[2] = '{w: 1'b0, r: 1'b1, d: 8'h00, exp_cnt: 0, exp_empty: 1'b1, exp_full: 1'b0, rd_chk: 1'b0, exp_rd: 8'h00};
    vt[3] = '{w: 1'b1, r: 1'b1, d: 8'h3C, exp_cnt: 1, exp_empty: 1'b0, exp_full: 1'b0, rd_chk: 1'b1, exp_rd: 8'h3C};
    vt[4] = '{w: 1'b1, r: 1'b1, d: 8'h5A, exp_cnt: 1, exp_empty: 1'b0, exp_full: 1'b0, rd_chk: 1'b1, exp_rd: 8'h5A};
    vt[5] = '{w: 1'b0, r: 1'b1, d: 8'h00, exp_cnt: 0, exp_empty: 1'b1, exp_full: 1'b0, rd_chk: 1'b0, exp_rd: 8'h00};

    // Reset and idle.
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_count",  32'(count),         32'd0);
    check("rst_rempty", 32'(rempty),        32'd1);
    check("rst_raempty",32'(ralmost_empty), 32'd1);
    check("rst_wfull",  32'(wfull),         32'd0);
    check("rst_wafull", 32'(walmost_full),  32'd0);

    // Single-word and simultaneous-on-empty vectors.
    for (int i = 0; i < 6; i++) begin
      cyc(vt[i].w, vt[i].r, vt[i].d);
      check("vec_count",  32'(count),  32'(vt[i].exp_cnt));
      check("vec_rempty", 32'(rempty), 32'(vt[i].exp_empty));
      check("vec_wfull",  32'(wfull),  32'(vt[i].exp_full));
      if (vt[i].rd_chk) check("vec_rdata", 32'(rdata), 32'(vt[i].exp_rd));
    end

    // Fill 16, overflow attempt, drain 16 in order.
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(i));
    cyc(1'b1, 1'b0, 8'hEE);
    check("full_drop_count", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 8'h00);
    check("drained_count", 32'(count), 32'd0);

    // Full with simultaneous read and write: only the read is taken.
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(8'h40 + i));
    cyc(1'b1, 1'b1, 8'h77);
    check("full_rw_count", 32'(count), 32'd15);
    check("full_rw_wfull", 32'(wfull), 32'd0);
    for (int i = 0; i < 15; i++) cyc(1'b0, 1'b1, 8'h00);

    // Streaming at half occupancy across two pointer wraps.
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 8'(8'h80 + i));
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 1'b1, 8'(8'h88 + i));
      check("stream_count", 32'(count), 32'd8);
    end
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 8'h00);

    // Asynchronous reset mid-stream with 7 words held.
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 8'(8'hC0 + i));
    check("pre_rst_count", 32'(count), 32'd7);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("arst_count",   32'(count),         32'd0);
    check("arst_rempty",  32'(rempty),        32'd1);
    check("arst_raempty", 32'(ralmost_empty), 32'd1);
    check("arst_wfull",   32'(wfull),         32'd0);
    check("arst_wafull",  32'(walmost_full),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_state();

`ifdef SYNC_FIFO_ERR_EN
    check("ovf_reset", 32'(overflow),  32'd0);
    check("unf_reset", 32'(underflow), 32'd0);
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(i));
    cyc(1'b1, 1'b0, 8'hFF);
    check("ovf_set", 32'(overflow), 32'd1);
    cyc(1'b0, 1'b0, 8'h00);
    check("ovf_hold", 32'(overflow), 32'd1);
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 8'h00);
    check("unf_clear_before", 32'(underflow), 32'd0);
    cyc(1'b0, 1'b1, 8'h00);
    check("unf_set", 32'(underflow), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("ovf_clr", 32'(overflow),  32'd0);
    check("unf_clr", 32'(underflow), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
